// File: rtl/fma_share_arbiter.sv
// Round-robin arbiter sharing one pipelined FMA among N_REQ requesters, with tagged results and a drain handshake.
// Optional issue/conflict statistics counters are enabled with `define FMA_ARB_STATS_EN.
module fma_share_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MUL_W   = 16,
   parameter int ACC_W   = 32,
   parameter int FMA_LAT = 5,
   localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*MUL_W-1:0]   req_mult1,
   input  logic [N_REQ*MUL_W-1:0]   req_mult2,
   input  logic [N_REQ*ACC_W-1:0]   req_acc,
   output logic [MUL_W-1:0]         fma_mult1,
   output logic [MUL_W-1:0]         fma_mult2,
   output logic [ACC_W-1:0]         fma_acc,
   input  logic [ACC_W-1:0]         fma_out,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [ACC_W-1:0]         rsp_data,
   input  logic                     drain_req,
   output logic                     drain_done,
   output logic                     busy
`ifdef FMA_ARB_STATS_EN
   ,
   output logic [31:0]              stat_issue_cnt,
   output logic [31:0]              stat_conflict_cnt
`endif
);

   localparam int CNT_W = $clog2(FMA_LAT + 3);

   typedef enum logic [1:0] {RUN, DRAINING, DRAINED} arbState_t;

   arbState_t        state, stateNext;
   logic [ID_W-1:0]  rrPtr;
   logic [ID_W-1:0]  winId;
   logic             grantValid;
   logic [FMA_LAT:0] tagValid;
   logic [ID_W-1:0]  tagId [FMA_LAT+1];
   logic [CNT_W-1:0] inFlight, inFlightNext;

   logic [MUL_W-1:0] mult1Arr [N_REQ];
   logic [MUL_W-1:0] mult2Arr [N_REQ];
   logic [ACC_W-1:0] accArr   [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign mult1Arr[gi] = req_mult1[gi*MUL_W +: MUL_W];
         assign mult2Arr[gi] = req_mult2[gi*MUL_W +: MUL_W];
         assign accArr[gi]   = req_acc[gi*ACC_W +: ACC_W];
      end
   endgenerate

   // Search upward from the requester after the last winner, wrapping at N_REQ.
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      winId      = '0;
      grantValid = 1'b0;
      sum        = '0;
      idx        = '0;
      if (state == RUN && !drain_req) begin
         for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, rrPtr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
               sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!grantValid && req_valid[idx]) begin
               grantValid = 1'b1;
               winId      = idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grantValid)
         req_ready[winId] = 1'b1;
   end

   always_comb begin
      inFlightNext = inFlight;
      case ({grantValid, rsp_valid})
         2'b10:   inFlightNext = inFlight + 1'b1;
         2'b01:   inFlightNext = inFlight - 1'b1;
         default: inFlightNext = inFlight;
      endcase
   end

   always_comb begin
      stateNext = state;
      case (state)
         RUN:      if (drain_req) stateNext = DRAINING;
         DRAINING: begin
            if (!drain_req)
               stateNext = RUN;
            else if (inFlight == '0)
               stateNext = DRAINED;
         end
         DRAINED:  if (!drain_req) stateNext = RUN;
         default:  stateNext = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         rrPtr     <= ID_W'(N_REQ - 1);
         fma_mult1 <= '0;
         fma_mult2 <= '0;
         fma_acc   <= '0;
         tagValid  <= '0;
         inFlight  <= '0;
         for (int k = 0; k <= FMA_LAT; k++)
            tagId[k] <= '0;
      end else begin
         state    <= stateNext;
         inFlight <= inFlightNext;
         // The tag pipe never stalls; its depth matches the FMA so tags line up with fma_out.
         tagValid <= {tagValid[FMA_LAT-1:0], grantValid};
         tagId[0] <= winId;
         for (int k = 1; k <= FMA_LAT; k++)
            tagId[k] <= tagId[k-1];
         if (grantValid) begin
            rrPtr     <= winId;
            fma_mult1 <= mult1Arr[winId];
            fma_mult2 <= mult2Arr[winId];
            fma_acc   <= accArr[winId];
         end
      end
   end

   assign rsp_valid  = tagValid[FMA_LAT];
   assign rsp_id     = tagId[FMA_LAT];
   assign rsp_data   = fma_out;
   assign busy       = (inFlight != '0);
   assign drain_done = (state == DRAINED);

`ifdef FMA_ARB_STATS_EN
   logic multiReq;
   assign multiReq = (req_valid & (req_valid - N_REQ'(1))) != '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issue_cnt    <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (grantValid && stat_issue_cnt != '1)
            stat_issue_cnt <= stat_issue_cnt + 1'b1;
         if (grantValid && multiReq && stat_conflict_cnt != '1)
            stat_conflict_cnt <= stat_conflict_cnt + 1'b1;
      end
   end
`endif

endmodule
